// File: rtl/gdi_gate_tester.sv
// Go/no-go tester for the GDI basic-gate layer: walks the four {a,b} vectors,
// samples the seven gate responses after a settle delay and accumulates error statistics.
module gdi_gate_tester #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] gate_out,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [6:0] err_mask,
    output logic [2:0] first_fail_gate,
    output logic [1:0] first_fail_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic [1:0] vec;

    logic [6:0] expected;
    logic [6:0] mism;
    logic [2:0] mism_cnt;
    logic [4:0] err_sum;
    logic [2:0] mism_low;

    // The stimulus pins come straight from the vector register, so they are
    // registered and hold 1/1 in DONE once the last vector has been applied.
    assign a = vec[1];
    assign b = vec[0];

    // Gate bit order: and, or, inv(a), nand, nor, xor, xnor.
    always_comb begin
        expected = {~(vec[1] ^ vec[0]),
                    vec[1] ^ vec[0],
                    ~(vec[1] | vec[0]),
                    ~(vec[1] & vec[0]),
                    ~vec[1],
                    vec[1] | vec[0],
                    vec[1] & vec[0]};
        mism = gate_out ^ expected;
    end

    always_comb begin
        mism_cnt = 3'd0;
        for (int i = 0; i < 7; i++) begin
            mism_cnt = mism_cnt + 3'(mism[i]);
        end
        err_sum = err_count + 5'(mism_cnt);
    end

    // Scan from the top so the lowest set index wins.
    always_comb begin
        mism_low = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (mism[i]) begin
                mism_low = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            settle_cnt      <= 4'd0;
            vec             <= 2'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 5'd0;
            err_mask        <= 7'd0;
            first_fail_gate <= 3'd0;
            first_fail_vec  <= 2'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= SETTLE;
                        settle_cnt      <= SETTLE_LOAD;
                        vec             <= 2'd0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= 5'd0;
                        err_mask        <= 7'd0;
                        first_fail_gate <= 3'd0;
                        first_fail_vec  <= 2'd0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    err_count <= err_sum;
                    err_mask  <= err_mask | mism;
                    // Only the very first failing sample records its location.
                    if ((mism != 7'd0) && (err_mask == 7'd0)) begin
                        first_fail_gate <= mism_low;
                        first_fail_vec  <= vec;
                    end
                    if (vec != 2'd3) begin
                        vec        <= vec + 2'd1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_sum == 5'd0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
